// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 command master.
package apb4_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned APB4_STRB_W = 4;
  localparam int unsigned APB4_PROT_W = 3;
  localparam int unsigned TMO_CNT_W   = 16;

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle including the bus clock and synchronous active-low reset.
interface apb4_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  hclk;
  logic                  hresetn;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  hclk, hresetn, prdata, pready, pslverr,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    input  hclk, hresetn, paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_cmd_master.sv
// APB4 initiator: valid/ready command in, one APB4 SETUP/ACCESS transfer,
// valid/ready response out. One transfer outstanding at a time.
// Optional ACCESS timeout is compiled in with APB4_MASTER_TIMEOUT_EN.
module apb4_cmd_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  apb4_if.master                apb4,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_write_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [APB4_STRB_W-1:0] cmd_strb_i,
  input  logic [APB4_PROT_W-1:0] cmd_prot_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o
);

  state_t state;

`ifdef APB4_MASTER_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt;
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);
`else
  assign rsp_tmo_o = 1'b0;
`endif

  // Transfer FSM; every APB and response output is a register written here.
  always_ff @(posedge apb4.hclk) begin
    if (!apb4.hresetn) begin
      state        <= IDLE;
      cmd_ready_o  <= 1'b0;
      apb4.psel    <= 1'b0;
      apb4.penable <= 1'b0;
      apb4.paddr   <= '0;
      apb4.pwrite  <= 1'b0;
      apb4.pwdata  <= '0;
      apb4.pstrb   <= '0;
      apb4.pprot   <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
      rsp_tmo_o    <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            apb4.paddr  <= cmd_addr_i;
            apb4.pwrite <= cmd_write_i;
            apb4.pwdata <= cmd_wdata_i;
            apb4.pstrb  <= cmd_write_i ? cmd_strb_i : '0;
            apb4.pprot  <= cmd_prot_i;
            apb4.psel   <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb4.penable <= 1'b1;
`ifdef APB4_MASTER_TIMEOUT_EN
          tmo_cnt      <= '0;
`endif
          state        <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout expiring in the same cycle
          if (apb4.pready) begin
            apb4.psel    <= 1'b0;
            apb4.penable <= 1'b0;
            rsp_rdata_o  <= apb4.pwrite ? '0 : apb4.prdata;
            rsp_err_o    <= apb4.pslverr;
`ifdef APB4_MASTER_TIMEOUT_EN
            rsp_tmo_o    <= 1'b0;
`endif
            rsp_valid_o  <= 1'b1;
            state        <= RESP;
          end
`ifdef APB4_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            apb4.psel    <= 1'b0;
            apb4.penable <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b1;
            rsp_tmo_o    <= 1'b1;
            rsp_valid_o  <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
